proc_mem_resp: RTL and testbench

- Memory-side responder for the processor's load/store and fetch port. It is the slave end of the request/acknowledge interface driven by the processor data path.
- Accepts one request at a time and inserts a programmable number of wait states. It then performs the read or write on an internal word array and returns a single-cycle acknowledge with read data and error status.
- Sits between the processor and the unified instruction/data memory.

---
 rtl/proc_mem_resp.sv | 127 ++++++++++++
 tb/tb_proc_mem_resp.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_mem_resp.sv
// Memory-side responder for the processor request/acknowledge port: one request at a time,
// WAIT_STATES wait cycles, single-cycle ack. Define PROC_MEM_BYTE_EN to add byte write enables (i_be).
module proc_mem_resp #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 2,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic                    i_we,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
`ifdef PROC_MEM_BYTE_EN
    input  logic [DATA_WIDTH/8-1:0] i_be,
`endif
    output logic                    o_ready,
    output logic                    o_ack,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_err
);

    // state  | meaning
    // S_IDLE | ready; a request is latched here
    // S_WAIT | counting down the programmed wait states
    // S_RESP | access executes; ack, data and write land on the edge that ends this state

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              wait_cnt;
    logic                    lat_we;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [NB-1:0]           lat_be;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic [ADDR_WIDTH-3:0]   word_idx;
    logic [IDX_W-1:0]        mem_idx;
    logic                    fault;
    logic                    accept;
    logic                    do_write;

    assign accept   = (state == S_IDLE) && i_req;
    assign word_idx = lat_addr[ADDR_WIDTH-1:2];
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign fault    = (lat_addr[1:0] != 2'b00) || (word_idx >= (ADDR_WIDTH-2)'(MEM_DEPTH));
    assign do_write = (state == S_RESP) && lat_we && !fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (i_req) state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            S_WAIT: if (wait_cnt == 4'd1) state_nxt = S_RESP;
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= 4'(WAIT_STATES);
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Request fields are frozen at acceptance; later bus activity cannot disturb the access.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= i_we;
            lat_addr  <= i_addr;
            lat_wdata <= i_wdata;
        end
    end

`ifdef PROC_MEM_BYTE_EN
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_be <= i_be;
        end
    end
`else
    assign lat_be = '1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            o_ack   <= 1'b0;
            o_rdata <= '0;
            o_err   <= 1'b0;
        end else begin
            o_ack <= (state == S_RESP);
            if (state == S_RESP) begin
                o_err   <= fault;
                o_rdata <= (!lat_we && !fault) ? mem[mem_idx] : '0;
            end
        end
    end

    // Gated by rst so a reset landing on the RESP edge abandons the write.
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            for (int b = 0; b < NB; b++) begin
                if (lat_be[b]) mem[mem_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_proc_mem_resp.sv
// Randomized bench for proc_mem_resp: a WAIT_STATES=2 and a WAIT_STATES=0 instance share one
// request stream and are checked against a word-array reference model.
module tb_proc_mem_resp;

    localparam int WS_A = 2;
`ifdef PROC_MEM_BYTE_EN
    localparam bit BE_ON = 1'b1;
`else
    localparam bit BE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic        i_we;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
`ifdef PROC_MEM_BYTE_EN
    logic [3:0]  i_be;
`endif
    logic        rdy_a, ack_a, err_a;
    logic [31:0] rdata_a;
    logic        rdy_z, ack_z, err_z;
    logic [31:0] rdata_z;

    logic [31:0] ref_mem [1024];
    bit          ref_vld [1024];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    proc_mem_resp dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
`ifdef PROC_MEM_BYTE_EN
        .i_be(i_be),
`endif
        .o_ready(rdy_a), .o_ack(ack_a), .o_rdata(rdata_a), .o_err(err_a)
    );

    proc_mem_resp #(.WAIT_STATES(0)) dut_z (
        .clk(clk), .rst(rst), .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
`ifdef PROC_MEM_BYTE_EN
        .i_be(i_be),
`endif
        .o_ready(rdy_z), .o_ack(ack_z), .o_rdata(rdata_z), .o_err(err_z)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        int c;
        c = $urandom_range(0, 9);
        if (c < 7) return 32'($urandom_range(0, 15)) << 2;
        if (c < 9) return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 0) return 32'hFFFF_FFFC;
        return 32'h1000 + (32'($urandom_range(0, 1000)) << 2);
    endfunction

    // Issue one request at a negedge with both instances idle; returns at the main instance's ack cycle,
    // which is the earliest cycle a follow-up request may be presented.
    task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input bit poke, output logic [31:0] rd_got);
        bit          good;
        int          idx;
        logic [31:0] exp_rd;
        bit          cmp_rd;
        logic [3:0]  be_eff;
        int          acks[2];
        int          ws[2];
        logic [31:0] got_rd[2];
        logic        got_err[2];
        logic        ackv[2];
        logic        rdyv[2];
        ws[0] = WS_A; ws[1] = 0;
        acks[0] = 0; acks[1] = 0;
        got_rd[0] = '0; got_rd[1] = '0;
        got_err[0] = 1'b0; got_err[1] = 1'b0;
        be_eff = BE_ON ? be : 4'hF;

        chk("idle_ready_a", 32'(rdy_a), 32'd1);
        chk("idle_ready_z", 32'(rdy_z), 32'd1);

        good   = (addr[1:0] == 2'b00) && (addr < 32'h1000);
        idx    = good ? int'(addr >> 2) : 0;
        exp_rd = '0;
        cmp_rd = 1'b1;
        if (good && !we) begin
            exp_rd = ref_mem[idx];
            cmp_rd = ref_vld[idx];
        end
        if (good && we) begin
            ref_mem[idx] = merge(ref_mem[idx], wdata, be_eff);
            if (be_eff == 4'hF) ref_vld[idx] = 1'b1;
        end

        i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata;
`ifdef PROC_MEM_BYTE_EN
        i_be = be;
`endif
        @(posedge clk);
        for (int n = 1; n <= WS_A + 2; n++) begin
            @(negedge clk);
            ackv[0] = ack_a; ackv[1] = ack_z;
            rdyv[0] = rdy_a; rdyv[1] = rdy_z;
            for (int k = 0; k < 2; k++) begin
                chk(k == 0 ? "ack_timing_a" : "ack_timing_z", 32'(ackv[k]), 32'(n == ws[k] + 2));
                chk(k == 0 ? "ready_timing_a" : "ready_timing_z", 32'(rdyv[k]), 32'(n >= ws[k] + 2));
                if (ackv[k] === 1'b1) begin
                    acks[k]++;
                    got_rd[k]  = (k == 0) ? rdata_a : rdata_z;
                    got_err[k] = (k == 0) ? err_a : err_z;
                end
            end
            if (n == 1) begin
                i_req   = poke;
                i_we    = 1'b1;
                i_addr  = 32'($urandom_range(0, 15)) << 2;
                i_wdata = $urandom;
`ifdef PROC_MEM_BYTE_EN
                i_be    = 4'($urandom);
`endif
            end else begin
                i_req = 1'b0;
            end
        end

        for (int k = 0; k < 2; k++) begin
            chk(k == 0 ? "ack_count_a" : "ack_count_z", 32'(acks[k]), 32'd1);
            chk(k == 0 ? "err_a" : "err_z", 32'(got_err[k]), 32'(!good));
            if (cmp_rd) chk(k == 0 ? "rdata_a" : "rdata_z", got_rd[k], exp_rd);
        end
        rd_got = got_rd[0];
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] old;
        int          cnt_a;
        int          cnt_z;

        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = '0;
            ref_vld[i] = 1'b0;
        end
        rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0;
`ifdef PROC_MEM_BYTE_EN
        i_be = 4'hF;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_a", 32'(rdy_a), 32'd1);
        chk("rst_ack_a", 32'(ack_a), 32'd0);
        chk("rst_rdata_a", rdata_a, 32'd0);
        chk("rst_err_a", 32'(err_a), 32'd0);
        chk("rst_ready_z", 32'(rdy_z), 32'd1);
        chk("rst_ack_z", 32'(ack_z), 32'd0);
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("idle_no_ack_a", 32'(ack_a), 32'd0);
            chk("idle_no_ack_z", 32'(ack_z), 32'd0);
        end

        for (int w = 0; w < 16; w++) do_txn(1'b1, 32'(w) << 2, $urandom, 4'hF, 1'b0, rd);

        do_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, rd);
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, rd);
        chk("read_deadbeef", rd, 32'hDEAD_BEEF);

        do_txn(1'b1, 32'h6, 32'h1234_5678, 4'hF, 1'b0, rd);
        chk("misaligned_wr_rdata", rd, 32'h0);
        do_txn(1'b0, 32'h4, 32'h0, 4'hF, 1'b0, rd);
        do_txn(1'b0, 32'h1000, 32'h0, 4'hF, 1'b0, rd);

        do_txn(1'b1, 32'h8, 32'hCAFE_F00D, 4'hF, 1'b1, rd);
        do_txn(1'b0, 32'h8, 32'h0, 4'hF, 1'b0, rd);

        // Request held high: WS=0 instance accepts every 2 cycles, WS=2 instance every 4.
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0;
        cnt_a = 0; cnt_z = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            chk("b2b_ack_z", 32'(ack_z), 32'((n % 2 == 0) && (n <= 8)));
            chk("b2b_ack_a", 32'(ack_a), 32'((n == 4) || (n == 8)));
            if (ack_a === 1'b1) cnt_a++;
            if (ack_z === 1'b1) begin
                cnt_z++;
                chk("b2b_rdata_z", rdata_z, ref_mem[0]);
            end
            if (n == 8) i_req = 1'b0;
        end
        chk("b2b_count_z", 32'(cnt_z), 32'd4);
        chk("b2b_count_a", 32'(cnt_a), 32'd2);

        old = ref_mem[8];
        i_req = 1'b1; i_we = 1'b1; i_addr = 32'h20; i_wdata = ~old;
        @(posedge clk);
        @(negedge clk);
        i_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready_a", 32'(rdy_a), 32'd1);
        chk("abort_ready_z", 32'(rdy_z), 32'd1);
        chk("abort_ack_a", 32'(ack_a), 32'd0);
        chk("abort_ack_z", 32'(ack_z), 32'd0);
        chk("abort_err_a", 32'(err_a), 32'd0);
        chk("abort_rdata_a", rdata_a, 32'd0);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("abort_no_ack_a", 32'(ack_a), 32'd0);
            chk("abort_no_ack_z", 32'(ack_z), 32'd0);
        end
        do_txn(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, rd);
        chk("abort_keeps_old", rd, old);

`ifdef PROC_MEM_BYTE_EN
        do_txn(1'b1, 32'h14, 32'h1122_3344, 4'hF, 1'b0, rd);
        do_txn(1'b1, 32'h14, 32'hAABB_CCDD, 4'b0101, 1'b0, rd);
        do_txn(1'b0, 32'h14, 32'h0, 4'hF, 1'b0, rd);
        chk("be_merge", rd, 32'h11BB_33DD);
        do_txn(1'b1, 32'h14, 32'h5555_5555, 4'b0000, 1'b0, rd);
        do_txn(1'b0, 32'h14, 32'h0, 4'hF, 1'b0, rd);
        chk("be_zero_unchanged", rd, 32'h11BB_33DD);
`endif

        for (int t = 0; t < 200; t++) begin
            do_txn(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom),
                   ($urandom_range(0, 3) == 0), rd);
        end
        for (int w = 0; w < 16; w++) do_txn(1'b0, 32'(w) << 2, 32'h0, 4'hF, 1'b0, rd);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
